quantum_scheduler: RTL and testbench
====================================

# quantum_scheduler

Parametrised preemption and context-switch unit for the multiprogrammed processor. It generalises the single-process quantum logic to NPROC process slots. It keeps a per-process saved PC table and a ready mask, and provides a round-robin next-process suggestion. It sits beside the datapath and drives the PC jump address and shift-mode control whenever the OS is entered or a process is dispatched.

## Interface
Parameters:
- ADDR_W, 12, instruction address width
- CNT_W, 32, quantum counter and config data width
- NPROC, 4, number of process slots (power of two, ≥2)
- PID_W, 2, log2(NPROC)
- QUANTUM_RST, 500000, quantum value after reset

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cfg_op  in  2  0 none, 1 load quantum, 2 load mp_en, 3 load OS entry address
- cfg_data  in  CNT_W  config payload (quantum / bit0 / low ADDR_W bits)
- halt  in  1  current program finished (HALT instruction)
- delay  in  1  PC stall; quantum counter holds
- exec_proc  in  1  OS dispatch request
- exec_pid  in  PID_W  process to dispatch
- pc  in  ADDR_W  current instruction address
- rd_pid  in  PID_W  saved-PC table read index
- cs_req  out  1  preemption (context switch) now
- new_addr  out  ADDR_W  jump target for PC
- shift  out  2  0 none, 1 enter OS, 2 enter process
- saved_pc  out  ADDR_W  saved PC of rd_pid (combinational read)
- cur_pid  out  PID_W  running/last process
- ready  out  NPROC  per-slot ready mask
- next_pid  out  PID_W  round-robin suggestion
- next_valid  out  1  some slot is ready
- in_proc  out  1  1 in PROC state, 0 in OS state
- preempt_cnt  out  16  see Configuration

## Operation
- States: OS (reset state), PROC.
- Config (any state): op1 quantum<=cfg_data; op2 mp_en<=cfg_data[0]; op3 os_addr<=cfg_data[ADDR_W-1:0].
- OS: exec_proc=1 -> PROC, cur_pid<=exec_pid, ready[exec_pid]<=1, cnt<=0; new_addr=saved_pc[exec_pid], shift=2.
- PROC, halt=1: saved_pc[cur_pid]<=pc, ready[cur_pid]<=0, cnt<=0, -> OS; shift=1.
- PROC, mp_en=1, quantum≠0, cnt≥quantum, halt=0: cs_req=1, shift=1, saved_pc[cur_pid]<=pc, cnt<=0, -> OS; ready unchanged.
- PROC otherwise: cnt increments if mp_en=1 and delay=0, else holds. Increment saturates at all-ones.
- new_addr in halt/cs_req cycles: os_addr if mp_en=1, else 0. In other cycles: saved_pc[exec_pid]. Only meaningful when shift≠0.
- quantum=0 or mp_en=0: preemption disabled.
- exec_proc in PROC ignored; halt in OS ignored (shift=0).
- halt and cs condition together: halt wins (ready bit cleared, cs_req=0).
- Quantum lowered below cnt: preemption on the next PROC cycle (≥ compare).
- next_pid: first ready slot scanning cur_pid+1, cur_pid+2, … wrapping modulo NPROC, cur_pid last. next_valid=|ready. next_pid=0 if none ready.
- Reset values: state OS, cnt 0, quantum QUANTUM_RST, mp_en 0, os_addr 0, saved_pc all 0, ready 0, cur_pid 0. Outputs: cs_req 0, shift 0, in_proc 0, new_addr 0, next_valid 0, preempt_cnt 0.

## Timing
- cs_req, shift, new_addr, next_pid, saved_pc: combinational from registered state and inputs, same cycle.
- State, table, ready and counter updates take effect on the next rising edge.
- Quantum q gives exactly q+1 PROC cycles without delay, cs_req on the last of them. Each delay cycle extends this by one.
- Config write is visible on the following cycle's compare.
- Reset mid-PROC: asynchronous return to reset values, including the table.

## Configuration
- QSCHED_PREEMPT_CNT_EN defined: preempt_cnt counts cs_req events, saturating at 16'hFFFF, cleared by reset only.
- Not defined: preempt_cnt tied to 0 and no counter logic.

## Test plan
- Reset, mp_en=1, quantum=3, dispatch pid 2 -> cs_req high on 4th PROC cycle, saved_pc[2]=pc at that cycle, new_addr=os_addr, shift=1.
- Same with delay high for 2 cycles mid-run -> cs_req on 6th PROC cycle.
- halt in PROC for pid 1 at pc=0x05A -> ready[1]=0, saved_pc[1]=0x05A, cs_req=0, new_addr=os_addr (or 0 with mp_en=0).
- ready=4'b1011, cur_pid=1 -> next_pid=3. cur_pid=3 -> next_pid=0. ready=0 -> next_valid=0.
- halt coinciding with cnt==quantum -> halt path only; preempt_cnt unchanged (macro on).
- Re-dispatch pid 2 after preemption -> new_addr=saved_pc[2], shift=2. Reset asserted mid-PROC -> all outputs at reset values immediately.

Source files
------------

// File: rtl/quantum_scheduler.sv
// quantum_scheduler
//   Preemption and context-switch unit for NPROC process slots. Tracks the
//   running process, a saved-PC table, a ready mask and a quantum counter.
//   Drives the PC jump target and shift-mode control whenever the OS is
//   entered (halt or quantum expiry) or a process is dispatched. Also offers
//   a round-robin suggestion for the next process to run.
//
// Optional feature: define QSCHED_PREEMPT_CNT_EN to get a saturating 16-bit
//   count of preemption events on preempt_cnt; otherwise preempt_cnt is 0.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   cfg_op, cfg_data      1 quantum, 2 mp_en (bit0), 3 OS entry address
//   halt, delay           program finished / PC stall (counter holds)
//   exec_proc, exec_pid   OS dispatch request and target slot
//   pc                    current instruction address
//   rd_pid, saved_pc      combinational read port of the saved-PC table
//   cs_req, new_addr      preemption now / PC jump target
//   shift                 0 none, 1 enter OS, 2 enter process
//   cur_pid, ready        running/last process, per-slot ready mask
//   next_pid, next_valid  round-robin suggestion, some slot ready
//   in_proc               1 while a process runs
//   preempt_cnt           preemption event count (optional)
module quantum_scheduler #(
  parameter int ADDR_W      = 12,
  parameter int CNT_W       = 32,
  parameter int NPROC       = 4,
  parameter int PID_W       = 2,
  parameter int QUANTUM_RST = 500000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        cfg_op,
  input  logic [CNT_W-1:0]  cfg_data,
  input  logic              halt,
  input  logic              delay,
  input  logic              exec_proc,
  input  logic [PID_W-1:0]  exec_pid,
  input  logic [ADDR_W-1:0] pc,
  input  logic [PID_W-1:0]  rd_pid,
  output logic              cs_req,
  output logic [ADDR_W-1:0] new_addr,
  output logic [1:0]        shift,
  output logic [ADDR_W-1:0] saved_pc,
  output logic [PID_W-1:0]  cur_pid,
  output logic [NPROC-1:0]  ready,
  output logic [PID_W-1:0]  next_pid,
  output logic              next_valid,
  output logic              in_proc,
  output logic [15:0]       preempt_cnt
);

  typedef enum logic {OS = 1'b0, PROC = 1'b1} stateT;

  stateT             state, stateNext;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  quantum;
  logic              mpEn;
  logic [ADDR_W-1:0] osAddr;
  logic [ADDR_W-1:0] pcTable [NPROC];
  logic [NPROC-1:0]  readyMask;
  logic [PID_W-1:0]  curPid;

  logic              haltEv;
  logic              preempt;
  logic              dispatch;
  logic [PID_W-1:0]  scanPid;
  logic [PID_W-1:0]  nextPidC;
  logic              found;

  // Halt has priority over an expired quantum: the process leaves for good
  // and the switch is not counted as a preemption.
  assign haltEv   = (state == PROC) && halt;
  assign preempt  = (state == PROC) && !halt && mpEn && (quantum != '0) && (cnt >= quantum);
  assign dispatch = (state == OS) && exec_proc;

  always_comb begin
    stateNext = state;
    shift     = 2'd0;
    new_addr  = pcTable[exec_pid];
    if (dispatch) begin
      stateNext = PROC;
      shift     = 2'd2;
    end else if (haltEv || preempt) begin
      stateNext = OS;
      shift     = 2'd1;
      new_addr  = mpEn ? osAddr : '0;
    end
  end

  // Round-robin scan starting just after the current process; the current
  // process itself is the last candidate (offset NPROC wraps to 0).
  always_comb begin
    nextPidC = '0;
    found    = 1'b0;
    scanPid  = '0;
    for (int k = 1; k <= NPROC; k++) begin
      scanPid = curPid + PID_W'(k);
      if (!found && readyMask[scanPid]) begin
        nextPidC = scanPid;
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= OS;
      cnt       <= '0;
      quantum   <= CNT_W'(QUANTUM_RST);
      mpEn      <= 1'b0;
      osAddr    <= '0;
      readyMask <= '0;
      curPid    <= '0;
      for (int i = 0; i < NPROC; i++) pcTable[i] <= '0;
    end else begin
      state <= stateNext;
      case (cfg_op)
        2'd1:    quantum <= cfg_data;
        2'd2:    mpEn    <= cfg_data[0];
        2'd3:    osAddr  <= cfg_data[ADDR_W-1:0];
        default: ;
      endcase
      if (dispatch) begin
        curPid              <= exec_pid;
        readyMask[exec_pid] <= 1'b1;
        cnt                 <= '0;
      end else if (haltEv) begin
        pcTable[curPid]   <= pc;
        readyMask[curPid] <= 1'b0;
        cnt               <= '0;
      end else if (preempt) begin
        pcTable[curPid] <= pc;
        cnt             <= '0;
      end else if (state == PROC && mpEn && !delay && cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef QSCHED_PREEMPT_CNT_EN
  logic [15:0] preemptCnt;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) preemptCnt <= '0;
    else if (preempt && preemptCnt != 16'hFFFF) preemptCnt <= preemptCnt + 16'd1;
  end
  assign preempt_cnt = preemptCnt;
`else
  assign preempt_cnt = 16'd0;
`endif

  assign cs_req     = preempt;
  assign saved_pc   = pcTable[rd_pid];
  assign cur_pid    = curPid;
  assign ready      = readyMask;
  assign next_pid   = nextPidC;
  assign next_valid = |readyMask;
  assign in_proc    = (state == PROC);

endmodule

// File: tb/tb_quantum_scheduler.sv
// Scoreboard bench for quantum_scheduler: each step drives inputs, pushes
// the expected outputs onto a queue, and drains the queue against the DUT
// before the next rising edge.
module tb_quantum_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  cfgOp;
  logic [31:0] cfgData;
  logic        halt, delay, execProc;
  logic [1:0]  execPid, rdPid;
  logic [11:0] pc;
  logic        csReq, nextValid, inProc;
  logic [11:0] newAddr, savedPc;
  logic [1:0]  shift, curPid, nextPid;
  logic [3:0]  ready;
  logic [15:0] preemptCnt;

  quantum_scheduler dut (
    .clock(clock), .reset(reset), .cfg_op(cfgOp), .cfg_data(cfgData),
    .halt(halt), .delay(delay), .exec_proc(execProc), .exec_pid(execPid),
    .pc(pc), .rd_pid(rdPid), .cs_req(csReq), .new_addr(newAddr),
    .shift(shift), .saved_pc(savedPc), .cur_pid(curPid), .ready(ready),
    .next_pid(nextPid), .next_valid(nextValid), .in_proc(inProc),
    .preempt_cnt(preemptCnt)
  );

  always #5 clock = ~clock;

  localparam int S_CS = 0, S_ADDR = 1, S_SHIFT = 2, S_SAVED = 3, S_CUR = 4,
                 S_READY = 5, S_NEXT = 6, S_NVALID = 7, S_INPROC = 8, S_PCNT = 9;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } expT;

  expT sb[$];
  int  checks   = 0;
  int  failures = 0;
  int  expPcnt  = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_CS:     return 32'(csReq);
      S_ADDR:   return 32'(newAddr);
      S_SHIFT:  return 32'(shift);
      S_SAVED:  return 32'(savedPc);
      S_CUR:    return 32'(curPid);
      S_READY:  return 32'(ready);
      S_NEXT:   return 32'(nextPid);
      S_NVALID: return 32'(nextValid);
      S_INPROC: return 32'(inProc);
      default:  return 32'(preemptCnt);
    endcase
  endfunction

  function automatic logic [31:0] pcntExp();
`ifdef QSCHED_PREEMPT_CNT_EN
    return 32'(expPcnt);
`else
    return 32'd0;
`endif
  endfunction

  task automatic expectOut(input string tag, input int sel, input logic [31:0] val);
    sb.push_back('{tag, sel, val});
  endtask

  task automatic drain();
    expT e;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkVal(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg(input logic [1:0] op, input logic [31:0] data);
    cfgOp = op; cfgData = data;
    tick();
    cfgOp = 2'd0;
  endtask

  task automatic dispatch(input logic [1:0] pid, input logic [11:0] expAddr);
    execProc = 1'b1; execPid = pid;
    expectOut("disp_shift", S_SHIFT, 32'd2);
    expectOut("disp_addr", S_ADDR, 32'(expAddr));
    expectOut("disp_cs", S_CS, 32'd0);
    drain();
    tick();
    execProc = 1'b0;
  endtask

  task automatic procCycle(input logic [11:0] pcv, input logic dl, input logic hl,
                           input logic expCs, input logic [1:0] expShift,
                           input logic [11:0] expAddr);
    pc = pcv; delay = dl; halt = hl;
    expectOut("proc_inproc", S_INPROC, 32'd1);
    expectOut("proc_cs", S_CS, 32'(expCs));
    expectOut("proc_shift", S_SHIFT, 32'(expShift));
    if (expShift != 2'd0) expectOut("proc_addr", S_ADDR, 32'(expAddr));
    drain();
    tick();
    if (expCs) expPcnt++;
    delay = 1'b0; halt = 1'b0;
  endtask

  task automatic runPreempt(input logic [1:0] pid, input logic [11:0] expAddr);
    dispatch(pid, expAddr);
    procCycle(12'h500 + 12'(pid) * 12'd2, 1'b0, 1'b0, 1'b0, 2'd0, 12'h0);
    procCycle(12'h501 + 12'(pid) * 12'd2, 1'b0, 1'b0, 1'b1, 2'd1, 12'h300);
  endtask

  initial begin
    reset = 1'b1; cfgOp = 2'd0; cfgData = '0; halt = 1'b0; delay = 1'b0;
    execProc = 1'b0; execPid = '0; rdPid = '0; pc = '0;
    tick();
    expectOut("rst_cs", S_CS, 0);
    expectOut("rst_shift", S_SHIFT, 0);
    expectOut("rst_inproc", S_INPROC, 0);
    expectOut("rst_addr", S_ADDR, 0);
    expectOut("rst_nvalid", S_NVALID, 0);
    expectOut("rst_pcnt", S_PCNT, 0);
    expectOut("rst_cur", S_CUR, 0);
    expectOut("rst_ready", S_READY, 0);
    drain();
    reset = 1'b0;
    tick();

    cfg(2'd2, 32'd1);
    cfg(2'd1, 32'd3);
    cfg(2'd3, 32'h300);

    // quantum 3, pid 2: preemption on the 4th PROC cycle; dispatch request
    // during PROC is ignored
    dispatch(2'd2, 12'h0);
    execProc = 1'b1; execPid = 2'd0;
    for (int i = 0; i < 4; i++) begin
      procCycle(12'h100 + 12'(i), 1'b0, 1'b0, i == 3, (i == 3) ? 2'd1 : 2'd0, 12'h300);
      execProc = 1'b0;
    end
    rdPid = 2'd2; halt = 1'b1;
    expectOut("cs_saved2", S_SAVED, 32'h103);
    expectOut("cs_inproc", S_INPROC, 0);
    expectOut("cs_ready", S_READY, 32'b0100);
    expectOut("cs_cur", S_CUR, 2);
    expectOut("cs_pcnt", S_PCNT, pcntExp());
    expectOut("os_halt_shift", S_SHIFT, 0);
    drain();
    halt = 1'b0;

    // re-dispatch pid 2 with two delay cycles: preemption on the 6th cycle
    dispatch(2'd2, 12'h103);
    for (int i = 1; i <= 6; i++)
      procCycle(12'h200 + 12'(i), (i == 2 || i == 3), 1'b0, i == 6, (i == 6) ? 2'd1 : 2'd0, 12'h300);
    expectOut("dly_saved2", S_SAVED, 32'h206);
    drain();

    // halt of pid 1 at 0x05A
    dispatch(2'd1, 12'h0);
    procCycle(12'h05A, 1'b0, 1'b1, 1'b0, 2'd1, 12'h300);
    rdPid = 2'd1;
    expectOut("halt_saved1", S_SAVED, 32'h05A);
    expectOut("halt_ready", S_READY, 32'b0100);
    drain();

    // halt coinciding with expired quantum: halt path only
    dispatch(2'd0, 12'h0);
    for (int i = 0; i < 3; i++) procCycle(12'h040 + 12'(i), 1'b0, 1'b0, 1'b0, 2'd0, 12'h0);
    procCycle(12'h077, 1'b0, 1'b1, 1'b0, 2'd1, 12'h300);
    rdPid = 2'd0;
    expectOut("hcs_saved0", S_SAVED, 32'h077);
    expectOut("hcs_ready", S_READY, 32'b0100);
    expectOut("hcs_pcnt", S_PCNT, pcntExp());
    drain();

    // empty ready mask, then build 4'b1011 for round-robin checks
    dispatch(2'd2, 12'h206);
    procCycle(12'h088, 1'b0, 1'b1, 1'b0, 2'd1, 12'h300);
    expectOut("empty_ready", S_READY, 0);
    expectOut("empty_nvalid", S_NVALID, 0);
    expectOut("empty_next", S_NEXT, 0);
    drain();
    cfg(2'd1, 32'd1);
    runPreempt(2'd0, 12'h077);
    runPreempt(2'd3, 12'h0);
    runPreempt(2'd1, 12'h05A);
    expectOut("rr_ready", S_READY, 32'b1011);
    expectOut("rr_cur1", S_CUR, 1);
    expectOut("rr_next_from1", S_NEXT, 3);
    expectOut("rr_nvalid", S_NVALID, 1);
    drain();
    runPreempt(2'd3, 12'h507);
    expectOut("rr_cur3", S_CUR, 3);
    expectOut("rr_next_from3", S_NEXT, 0);
    expectOut("rr_pcnt", S_PCNT, pcntExp());
    drain();

    // asynchronous reset in the middle of a PROC cycle
    dispatch(2'd0, 12'h501);
    procCycle(12'h600, 1'b0, 1'b0, 1'b0, 2'd0, 12'h0);
    #2 reset = 1'b1;
    expPcnt = 0;
    #1;
    rdPid = 2'd3; halt = 1'b1; pc = 12'h0AB;
    expectOut("mrst_inproc", S_INPROC, 0);
    expectOut("mrst_cs", S_CS, 0);
    expectOut("mrst_shift", S_SHIFT, 0);
    expectOut("mrst_ready", S_READY, 0);
    expectOut("mrst_cur", S_CUR, 0);
    expectOut("mrst_nvalid", S_NVALID, 0);
    expectOut("mrst_saved3", S_SAVED, 0);
    expectOut("mrst_pcnt", S_PCNT, 0);
    drain();
    halt = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // mp_en back to 0 after reset: halt jumps to address 0
    dispatch(2'd1, 12'h0);
    procCycle(12'h0AA, 1'b0, 1'b1, 1'b0, 2'd1, 12'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
